mem_req_scheduler: RTL and testbench

- Request front-end that sits directly upstream of the multi-bank memory.
- Accepts write/read requests over a valid/ready handshake and buffers them in order. Issues at most one access per cycle on the memory's we/bank_sel/addr/din interface.
- Captures the memory's registered read data and returns it over a valid/ready response channel with back-pressure.
- Writes produce no response.

---
 rtl/mem_sched_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/mem_req_scheduler.sv | 147 ++++++++++++++
 tb/tb_mem_req_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared widths and transaction types for the memory request
// scheduler. The module parameters of mem_req_scheduler default to these
// widths; the request/response structs are built from the same values.
package mem_sched_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int BANK_BITS  = 2;

    // One queued memory access.
    typedef struct packed {
        logic                  we;
        logic [BANK_BITS-1:0]  bank;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    // One captured read result.
    typedef struct packed {
        logic [BANK_BITS-1:0]  bank;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered occupancy count.
//   clk, rst_n       : clock, asynchronous active-low reset
//   push_i, wdata_i  : write side; a push while full is dropped, even if a
//                      pop happens in the same cycle
//   pop_i, rdata_o   : read side; rdata_o shows the head entry
//   full_o, empty_o  : derived from the registered count
//   count_o          : number of stored entries
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q;
    logic [AW-1:0]               rd_ptr_q;
    logic [CW-1:0]               count_q;
    logic                        do_push;
    logic                        do_pop;

    // Explicit wrap so depths that are not a power of two still work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage is reset so the head reads as zero while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler: in-order request front-end for a multi-bank memory with
// a 1-cycle registered read port.
//   clk, rst_n                          : clock, async active-low reset
//   req_valid/req_ready, req_we/bank/addr/wdata : request channel
//   mem_we/bank_sel/addr/din            : registered memory command
//   mem_dout                            : memory read data (1-cycle latency)
//   rsp_valid/rsp_ready, rsp_rdata/bank : read response channel
// Reads are only issued when the response buffer is guaranteed room for them
// (buffered + in-flight < RSP_DEPTH), so a response push never finds it full.
module mem_req_scheduler
    import mem_sched_pkg::*;
#(
    parameter int DATA_WIDTH = mem_sched_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_sched_pkg::ADDR_WIDTH,
    parameter int BANK_BITS  = mem_sched_pkg::BANK_BITS,
    parameter int REQ_DEPTH  = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [BANK_BITS-1:0]  req_bank,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  mem_we,
    output logic [BANK_BITS-1:0]  mem_bank_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [BANK_BITS-1:0]  rsp_bank
);

    localparam int RQ_CW = $clog2(REQ_DEPTH + 1);
    localparam int RS_CW = $clog2(RSP_DEPTH + 1);
    localparam int CR_W  = RS_CW + 1;

    req_t              req_in;
    req_t              req_head;
    logic              req_full;
    logic              req_empty;
    logic [RQ_CW-1:0]  req_count;
    logic              unused_req_count;

    rsp_t              rsp_in;
    rsp_t              rsp_head;
    logic              rsp_push;
    logic              rsp_pop;
    logic              rsp_full;
    logic              rsp_empty;
    logic [RS_CW-1:0]  rsp_count;

    logic [CR_W-1:0]   credit_used;
    logic              credit_ok;
    logic              issue;

    logic                  mem_we_q;
    logic [BANK_BITS-1:0]  mem_bank_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_din_q;

    // rd_vld_q[0]: read command on mem_*; rd_vld_q[1]: mem_dout holds read data
    logic [1:0]            rd_vld_q;
    logic [BANK_BITS-1:0]  rd_bank_q;

    // ---------------- request queue ----------------
    assign req_in    = '{we: req_we, bank: req_bank, addr: req_addr, wdata: req_wdata};
    assign req_ready = !req_full;
    assign unused_req_count = ^req_count;

    sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_valid),
        .wdata_i (req_in),
        .pop_i   (issue),
        .rdata_o (req_head),
        .full_o  (req_full),
        .empty_o (req_empty),
        .count_o (req_count)
    );

    // ---------------- issue ----------------
    // Credit is conservative: a response popped this cycle frees its slot next cycle.
    assign credit_used = CR_W'(rsp_count) + CR_W'(rd_vld_q[0]) + CR_W'(rd_vld_q[1]);
    assign credit_ok   = credit_used < CR_W'(RSP_DEPTH);
    assign issue       = !req_empty && (req_head.we || credit_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q   <= 1'b0;
            mem_bank_q <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rd_vld_q   <= '0;
            rd_bank_q  <= '0;
        end else begin
            mem_we_q <= issue && req_head.we;
            if (issue) begin
                mem_bank_q <= req_head.bank;
                mem_addr_q <= req_head.addr;
                if (req_head.we) begin
                    mem_din_q <= req_head.wdata;
                end
            end
            rd_vld_q  <= {rd_vld_q[0], issue && !req_head.we};
            // Tracks the bank of the command one stage behind, i.e. the bank
            // whose data is on mem_dout when rd_vld_q[1] is set.
            rd_bank_q <= mem_bank_q;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_bank_sel = mem_bank_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;

    // ---------------- response buffer ----------------
    assign rsp_push = rd_vld_q[1];
    assign rsp_in   = '{bank: rd_bank_q, rdata: mem_dout};
    assign rsp_pop  = rsp_valid && rsp_ready;

    sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rsp_push),
        .wdata_i (rsp_in),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );

    assign rsp_valid = !rsp_empty;
    assign rsp_rdata = rsp_head.rdata;
    assign rsp_bank  = rsp_head.bank;

    // Credit accounting must make a push into a full response buffer impossible.
    a_no_rsp_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_push && rsp_full));

endmodule

// File: tb/tb_mem_req_scheduler.sv
module tb_mem_req_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [1:0] req_bank = '0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       mem_we;
    logic [1:0] mem_bank_sel;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_bank;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_req_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_we(mem_we), .mem_bank_sel(mem_bank_sel), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_bank(rsp_bank)
    );

    // Memory model: 4 banks x 16 words, registered read port.
    logic [7:0] mem_arr [4][16];
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_bank_sel][mem_addr] <= mem_din;
        mem_dout <= mem_arr[mem_bank_sel][mem_addr];
    end

    // Response monitor: every accepted response with the cycle it was taken.
    logic [7:0] qd[$];
    logic [1:0] qb[$];
    int         qc[$];
    int         cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && rsp_valid && rsp_ready) begin
            qd.push_back(rsp_rdata);
            qb.push_back(rsp_bank);
            qc.push_back(cyc);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [1:0] b, input logic [3:0] a, input logic [7:0] d);
        logic acc;
        int   t;
        req_valid = 1'b1; req_we = we; req_bank = b; req_addr = a; req_wdata = d;
        t = 0;
        do begin
            acc = req_ready;
            tick();
            t++;
        end while (!acc && t < 50);
        req_valid = 1'b0;
        n_cmp++;
        if (acc !== 1'b1) begin n_bad++; $display("FAIL send_accept: req_ready=%b after %0d cycles, want 1", acc, t); end
    endtask

    task automatic wait_rsp(input int n);
        int t;
        t = 0;
        while (qd.size() < n && t < 100) begin tick(); t++; end
        n_cmp++;
        if (qd.size() < n) begin n_bad++; $display("FAIL wait_rsp: got %0d responses, want %0d", qd.size(), n); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (req_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (mem_we !== 1'b0)       begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_bank_sel !== 2'd0) begin n_bad++; $display("FAIL reset_mem_bank: got %h want 0", mem_bank_sel); end
        n_cmp++; if (mem_addr !== 4'd0)     begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_din !== 8'd0)      begin n_bad++; $display("FAIL reset_mem_din: got %h want 0", mem_din); end
        n_cmp++; if (rsp_rdata !== 8'd0)    begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if (rsp_bank !== 2'd0)     begin n_bad++; $display("FAIL reset_rsp_bank: got %h want 0", rsp_bank); end
    endtask

    task automatic test_write_read;
        int base;
        base = qd.size();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_bank = 2'd2; req_addr = 4'd5; req_wdata = 8'hA5;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready: got %b want 1", req_ready); end
        tick();                                     // write accepted
        req_we = 1'b0; req_wdata = 8'h00;
        tick();                                     // read accepted (k)
        req_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1)       begin n_bad++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
        n_cmp++; if (mem_bank_sel !== 2'd2) begin n_bad++; $display("FAIL wr_mem_bank: got %h want 2", mem_bank_sel); end
        n_cmp++; if (mem_addr !== 4'd5)     begin n_bad++; $display("FAIL wr_mem_addr: got %h want 5", mem_addr); end
        n_cmp++; if (mem_din !== 8'hA5)     begin n_bad++; $display("FAIL wr_mem_din: got %h want a5", mem_din); end
        tick();                                     // k+1: read on mem_*
        n_cmp++; if (mem_we !== 1'b0)       begin n_bad++; $display("FAIL rd_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 4'd5)     begin n_bad++; $display("FAIL rd_mem_addr: got %h want 5", mem_addr); end
        n_cmp++; if (rsp_valid !== 1'b0)    begin n_bad++; $display("FAIL rd_early1: rsp_valid %b want 0", rsp_valid); end
        tick();                                     // k+2
        n_cmp++; if (rsp_valid !== 1'b0)    begin n_bad++; $display("FAIL rd_early2: rsp_valid %b want 0", rsp_valid); end
        tick();                                     // k+3
        n_cmp++; if (rsp_valid !== 1'b1)    begin n_bad++; $display("FAIL rd_latency: rsp_valid %b want 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 8'hA5)   begin n_bad++; $display("FAIL rd_data: got %h want a5", rsp_rdata); end
        n_cmp++; if (rsp_bank !== 2'd2)     begin n_bad++; $display("FAIL rd_bank: got %h want 2", rsp_bank); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0)    begin n_bad++; $display("FAIL rd_popped: rsp_valid %b want 0", rsp_valid); end
        n_cmp++; if (qd.size() !== base + 1) begin n_bad++; $display("FAIL rd_count: got %0d want %0d", qd.size(), base + 1); end
    endtask

    task automatic preload;
        for (int i = 0; i < 8; i++) send(1'b1, 2'd1, 4'(i), 8'h10 + 8'(i));
        repeat (3) tick();
    endtask

    task automatic test_back_to_back;
        int base;
        logic [7:0] exp;
        base = qd.size();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(1'b0, 2'd1, 4'(i), 8'h00);
        wait_rsp(base + 8);
        for (int i = 0; i < 8 && base + i < qd.size(); i++) begin
            exp = 8'h10 + 8'(i);
            n_cmp++; if (qd[base+i] !== exp) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, qd[base+i], exp); end
            n_cmp++; if (qb[base+i] !== 2'd1) begin n_bad++; $display("FAIL b2b_bank[%0d]: got %h want 1", i, qb[base+i]); end
            if (i > 0) begin
                n_cmp++; if (qc[base+i] - qc[base+i-1] !== 1) begin n_bad++; $display("FAIL b2b_gap[%0d]: got %0d cycles want 1", i, qc[base+i] - qc[base+i-1]); end
            end
        end
    endtask

    task automatic test_backpressure_full;
        int base;
        int t;
        logic acc;
        logic [7:0] exp;
        base = qd.size();
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 2'd1, 4'(i), 8'h00);
        repeat (4) tick();
        n_cmp++; if (req_ready !== 1'b0)  begin n_bad++; $display("FAIL bp_req_ready: got %b want 0", req_ready); end
        n_cmp++; if (mem_we !== 1'b0)     begin n_bad++; $display("FAIL bp_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 4'd3)   begin n_bad++; $display("FAIL bp_last_issue: mem_addr %h want 3", mem_addr); end
        n_cmp++; if (rsp_valid !== 1'b1)  begin n_bad++; $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (qd.size() !== base)  begin n_bad++; $display("FAIL bp_no_pop: got %0d want %0d", qd.size(), base); end
        // Hold a write against the full queue.
        req_valid = 1'b1; req_we = 1'b1; req_bank = 2'd3; req_addr = 4'd9; req_wdata = 8'h5C;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL full_hold[%0d]: req_ready %b want 0", i, req_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        t = 0;
        do begin acc = req_ready; tick(); t++; end while (!acc && t < 20);
        req_valid = 1'b0;
        n_cmp++; if (t !== 3) begin n_bad++; $display("FAIL full_accept_cycle: got %0d want 3", t); end
        wait_rsp(base + 8);
        for (int i = 0; i < 8 && base + i < qd.size(); i++) begin
            exp = 8'h10 + 8'(i);
            n_cmp++; if (qd[base+i] !== exp) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, qd[base+i], exp); end
        end
        send(1'b0, 2'd3, 4'd9, 8'h00);
        wait_rsp(base + 9);
        if (qd.size() > base + 8) begin
            n_cmp++; if (qd[base+8] !== 8'h5C) begin n_bad++; $display("FAIL held_data: got %h want 5c", qd[base+8]); end
            n_cmp++; if (qb[base+8] !== 2'd3)  begin n_bad++; $display("FAIL held_bank: got %h want 3", qb[base+8]); end
        end
    endtask

    task automatic test_mid_reset;
        int base;
        base = qd.size();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(1'b0, 2'd1, 4'(i), 8'h00);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mr_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mr_req_ready: got %b want 1", req_ready); end
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) tick();
        n_cmp++; if (qd.size() !== base) begin n_bad++; $display("FAIL mr_no_rsp: got %0d want %0d", qd.size(), base); end
        n_cmp++; if (mem_we !== 1'b0)    begin n_bad++; $display("FAIL mr_mem_we: got %b want 0", mem_we); end
        send(1'b0, 2'd1, 4'd2, 8'h00);
        wait_rsp(base + 1);
        if (qd.size() > base) begin
            n_cmp++; if (qd[base] !== 8'h12) begin n_bad++; $display("FAIL mr_new_read: got %h want 12", qd[base]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        preload();
        test_back_to_back();
        test_backpressure_full();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
